// File: rtl/accum_warp_addr_serializer.sv
// accum_warp_addr_serializer: holds one vector of lane addresses and emits it as single-address beats.
// Optional AWL_SERIAL_SKIP_EN: skip invalid lanes; an all-zero mask yields a single bubble beat.
`default_nettype none

module accum_warp_addr_serializer #(
  parameter  int N_CFG   = 4,
  parameter  int ABW     = 10,
  parameter  int VSIZE   = 4,
  localparam int NCFG_BW = $clog2(N_CFG + 1),
  localparam int CV_BW   = $clog2(VSIZE)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           src_rdy,
  output logic                           src_ack,
  input  logic [NCFG_BW-1:0]             i_id,
  input  logic [VSIZE-1:0][ABW-1:0]      i_address,
  input  logic [VSIZE-1:0]               i_valid,
  input  logic                           i_retire,
  input  logic                           i_islast,
  output logic                           dst_rdy,
  input  logic                           dst_ack,
  output logic [NCFG_BW-1:0]             o_id,
  output logic [ABW-1:0]                 o_address,
  output logic [CV_BW-1:0]               o_lane,
  output logic                           o_valid,
  output logic                           o_last,
  output logic                           o_retire,
  output logic                           fin_dval
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e                    state_q;
  logic [VSIZE-1:0]          pend_q;
  logic [VSIZE-1:0]          pend_d;
  logic [VSIZE-1:0]          vmask_q;
  logic [VSIZE-1:0][ABW-1:0] addr_q;
  logic [NCFG_BW-1:0]        id_q;
  logic                      retire_q;
  logic                      islast_q;

  logic [CV_BW-1:0]          lane_w;
  logic [VSIZE-1:0]          lane_oh_w;
  logic [VSIZE-1:0]          load_pend_w;
  logic                      onehot_w;
  logic                      full_w;

  // Lowest set bit of the pending mask wins: iterate downward so the last hit is the lowest.
  always_comb begin
    lane_w = '0;
    for (int i = VSIZE - 1; i >= 0; i--) begin
      if (pend_q[i]) lane_w = CV_BW'(i);
    end
  end

  assign lane_oh_w = pend_q & (~pend_q + VSIZE'(1));
  assign onehot_w  = (pend_q != '0) && ((pend_q & (pend_q - VSIZE'(1))) == '0);
  assign full_w    = (state_q == S_FULL);

`ifdef AWL_SERIAL_SKIP_EN
  // An empty mask still occupies lane 0 as a bubble so retire/fin are not lost.
  assign load_pend_w = (i_valid == '0) ? VSIZE'(1) : i_valid;
`else
  assign load_pend_w = '1;
`endif

  assign dst_rdy   = full_w;
  assign o_id      = id_q;
  assign o_address = addr_q[lane_w];
  assign o_lane    = lane_w;
  assign o_valid   = full_w & vmask_q[lane_w];
  assign o_last    = full_w & onehot_w;
  assign o_retire  = o_last & retire_q;
  assign fin_dval  = dst_ack & o_last & islast_q;
  assign src_ack   = src_rdy & (~full_w | (dst_ack & o_last));

  always_comb begin
    pend_d = pend_q;
    if (src_ack) begin
      pend_d = load_pend_w;
    end else if (full_w && dst_ack) begin
      pend_d = pend_q & ~lane_oh_w;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_EMPTY;
      pend_q   <= '0;
      vmask_q  <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      retire_q <= 1'b0;
      islast_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        S_EMPTY: begin
          if (src_ack) state_q <= S_FULL;
        end
        S_FULL: begin
          if (dst_ack && onehot_w && !src_ack) state_q <= S_EMPTY;
        end
        default: state_q <= S_EMPTY;
      endcase
      if (src_ack) begin
        vmask_q  <= i_valid;
        addr_q   <= i_address;
        id_q     <= i_id;
        retire_q <= i_retire;
        islast_q <= i_islast;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accum_warp_addr_serializer.sv
// Self-checking bench for accum_warp_addr_serializer: vector table plus scoreboard of expected beats.
`default_nettype none

module tb_accum_warp_addr_serializer;

  localparam int N_CFG   = 4;
  localparam int ABW     = 10;
  localparam int VSIZE   = 4;
  localparam int NCFG_BW = $clog2(N_CFG + 1);
  localparam int CV_BW   = $clog2(VSIZE);

  logic                      clk = 1'b0;
  logic                      i_rst;
  logic                      src_rdy;
  logic                      src_ack;
  logic [NCFG_BW-1:0]        i_id;
  logic [VSIZE-1:0][ABW-1:0] i_address;
  logic [VSIZE-1:0]          i_valid;
  logic                      i_retire;
  logic                      i_islast;
  logic                      dst_rdy;
  logic                      dst_ack;
  logic [NCFG_BW-1:0]        o_id;
  logic [ABW-1:0]            o_address;
  logic [CV_BW-1:0]          o_lane;
  logic                      o_valid;
  logic                      o_last;
  logic                      o_retire;
  logic                      fin_dval;

  accum_warp_addr_serializer #(.N_CFG(N_CFG), .ABW(ABW), .VSIZE(VSIZE)) dut (
    .i_clk(clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack), .i_id(i_id),
    .i_address(i_address), .i_valid(i_valid), .i_retire(i_retire), .i_islast(i_islast),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_id(o_id), .o_address(o_address),
    .o_lane(o_lane), .o_valid(o_valid), .o_last(o_last), .o_retire(o_retire),
    .fin_dval(fin_dval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CV_BW-1:0]   lane;
    logic [ABW-1:0]     addr;
    logic               chk_addr;
    logic               valid;
    logic               last;
    logic               retire;
    logic               fin;
    logic [NCFG_BW-1:0] id;
  } beat_t;

  typedef struct {
    logic [VSIZE-1:0]          mask;
    logic [VSIZE-1:0][ABW-1:0] addr;
    logic [NCFG_BW-1:0]        id;
    logic                      ret;
    logic                      isl;
    bit                        rnd_ack;
    int                        beats_skip;
    int                        beats_full;
  } vec_t;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;
  bit    want_ack = 1'b0;
  bit    last_src = 1'b0;
  bit    last_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push_vec(input logic [VSIZE-1:0] m, input logic [VSIZE-1:0][ABW-1:0] a,
                                   input logic [NCFG_BW-1:0] id, input logic ret, input logic isl);
    beat_t b;
    int    hi;
    b.id  = id;
    b.fin = isl;
`ifdef AWL_SERIAL_SKIP_EN
    if (m == '0) begin
      b.lane = '0; b.addr = a[0]; b.chk_addr = 1'b0; b.valid = 1'b0;
      b.last = 1'b1; b.retire = ret;
      q.push_back(b);
    end else begin
      hi = 0;
      for (int i = 0; i < VSIZE; i++) if (m[i]) hi = i;
      for (int i = 0; i < VSIZE; i++) begin
        if (m[i]) begin
          b.lane = CV_BW'(i); b.addr = a[i]; b.chk_addr = 1'b1; b.valid = 1'b1;
          b.last = (i == hi); b.retire = (i == hi) ? ret : 1'b0;
          q.push_back(b);
        end
      end
    end
`else
    hi = VSIZE - 1;
    for (int i = 0; i < VSIZE; i++) begin
      b.lane = CV_BW'(i); b.addr = a[i]; b.chk_addr = 1'b1; b.valid = m[i];
      b.last = (i == hi); b.retire = (i == hi) ? ret : 1'b0;
      q.push_back(b);
    end
`endif
  endfunction

  // One cycle: called just after a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    bit exp_rdy, exp_src, exp_fin, front_last;
    dst_ack = want_ack && dst_rdy;
    #1;
    exp_rdy    = (q.size() != 0);
    front_last = exp_rdy ? q[0].last : 1'b0;
    exp_src    = src_rdy && (!exp_rdy || (dst_ack && front_last));
    exp_fin    = exp_rdy && dst_ack && front_last && q[0].fin;
    chk("dst_rdy", dst_rdy, exp_rdy);
    chk("src_ack", src_ack, exp_src);
    chk("fin_dval", fin_dval, exp_fin);
    if (dst_rdy && exp_rdy) begin
      chk("o_lane", o_lane, q[0].lane);
      chk("o_valid", o_valid, q[0].valid);
      chk("o_last", o_last, q[0].last);
      chk("o_retire", o_retire, q[0].retire);
      chk("o_id", o_id, q[0].id);
      if (q[0].chk_addr) chk("o_address", o_address, q[0].addr);
    end
    last_rdy = dst_rdy;
    last_src = src_ack;
    if (dst_rdy && dst_ack && exp_rdy) begin
      void'(q.pop_front());
      beats++;
    end
    if (src_ack) push_vec(i_valid, i_address, i_id, i_retire, i_islast);
    @(negedge clk);
  endtask

  task automatic drive_vec(input vec_t v);
    i_valid = v.mask; i_address = v.addr; i_id = v.id; i_retire = v.ret; i_islast = v.isl;
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 60; c++) begin
      if (!dst_rdy && q.size() == 0) break;
      want_ack = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    want_ack = 1'b0;
  endtask

  function automatic int exp_beats(input vec_t v);
`ifdef AWL_SERIAL_SKIP_EN
    return v.beats_skip;
`else
    return v.beats_full;
`endif
  endfunction

  vec_t tbl[7];
  vec_t va, vb;

  initial begin
    i_rst = 1'b1; src_rdy = 1'b0; dst_ack = 1'b0; i_id = '0; i_address = '0;
    i_valid = '0; i_retire = 1'b0; i_islast = 1'b0;

    tbl[0] = '{4'b1010, {10'h40, 10'h30, 10'h20, 10'h10}, 3'd1, 1'b0, 1'b0, 1'b0, 2, 4};
    tbl[1] = '{4'b0000, {10'h04, 10'h03, 10'h02, 10'h01}, 3'd2, 1'b1, 1'b1, 1'b0, 1, 4};
    tbl[2] = '{4'b1111, {10'h3ff, 10'h155, 10'h2aa, 10'h001}, 3'd3, 1'b1, 1'b0, 1'b0, 4, 4};
    tbl[3] = '{4'b0001, {10'h111, 10'h122, 10'h133, 10'h144}, 3'd4, 1'b0, 1'b1, 1'b0, 1, 4};
    tbl[4] = '{4'b1000, {10'h0aa, 10'h0bb, 10'h0cc, 10'h0dd}, 3'd0, 1'b1, 1'b1, 1'b0, 1, 4};
    tbl[5] = '{4'b0110, {10'h201, 10'h202, 10'h203, 10'h204}, 3'd2, 1'b1, 1'b1, 1'b1, 2, 4};
    tbl[6] = '{4'b0100, {10'h301, 10'h302, 10'h303, 10'h304}, 3'd1, 1'b0, 1'b0, 1'b1, 1, 4};

    repeat (2) @(negedge clk);
    chk("rst_dst_rdy", dst_rdy, 0); chk("rst_src_ack", src_ack, 0);
    chk("rst_o_id", o_id, 0);       chk("rst_o_address", o_address, 0);
    chk("rst_o_lane", o_lane, 0);   chk("rst_o_valid", o_valid, 0);
    chk("rst_o_last", o_last, 0);   chk("rst_o_retire", o_retire, 0);
    chk("rst_fin_dval", fin_dval, 0);
    i_rst = 1'b0;
    @(negedge clk);

    // Table: one vector at a time, beat count per vector checked against the table.
    foreach (tbl[k]) begin
      drive_vec(tbl[k]);
      src_rdy = 1'b1; want_ack = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (last_src) break;
      end
      src_rdy = 1'b0;
      beats = 0;
      drain(tbl[k].rnd_ack);
      chk($sformatf("beat_count_%0d", k), beats, exp_beats(tbl[k]));
    end

    // Back-to-back vectors with src_rdy and dst_ack held: beats must be contiguous.
    begin
      int nacc, first_c, last_c, cyc;
      va = tbl[2]; vb = tbl[3];
      drive_vec(va); src_rdy = 1'b1; want_ack = 1'b1;
      nacc = 0; first_c = -1; last_c = -1; beats = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
        tick();
        if (last_rdy) begin
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
        end
        if (last_src) begin
          nacc++;
          if (nacc == 1) drive_vec(vb);
          if (nacc == 2) src_rdy = 1'b0;
        end
        if (nacc >= 2 && !dst_rdy && q.size() == 0) break;
      end
      want_ack = 1'b0;
      chk("b2b_accepts", nacc, 2);
      chk("b2b_beats", beats, exp_beats(va) + exp_beats(vb));
      chk("b2b_span", last_c - first_c + 1, beats);
    end

    // Stall mid-vector with another vector offered: nothing may move, src_ack stays low.
    begin
      va = tbl[2]; va.isl = 1'b0;
      drive_vec(va); src_rdy = 1'b1; want_ack = 1'b0;
      tick();
      drive_vec(tbl[0]);
      want_ack = 1'b1; tick();
      want_ack = 1'b0; repeat (3) tick();
      chk("stall_q_depth", q.size(), exp_beats(va) - 1);
      want_ack = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (last_src) break;
      end
      src_rdy = 1'b0;
      drain(1'b0);
    end

    // Asynchronous reset while lane 2 of a full mask is pending.
    begin
      va = tbl[2]; va.isl = 1'b1; va.ret = 1'b1;
      drive_vec(va); src_rdy = 1'b1; want_ack = 1'b0;
      tick();
      src_rdy = 1'b0; want_ack = 1'b1;
      repeat (2) tick();
      want_ack = 1'b0;
      dst_ack = 1'b1;
      i_rst = 1'b1;
      #1;
      chk("arst_dst_rdy", dst_rdy, 0);   chk("arst_fin_dval", fin_dval, 0);
      chk("arst_o_address", o_address, 0); chk("arst_o_lane", o_lane, 0);
      chk("arst_o_valid", o_valid, 0);   chk("arst_o_last", o_last, 0);
      chk("arst_o_retire", o_retire, 0); chk("arst_o_id", o_id, 0);
      dst_ack = 1'b0;
      q.delete();
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
      va = tbl[2]; va.addr = {10'h0d4, 10'h0c3, 10'h0b2, 10'h0a1};
      drive_vec(va); src_rdy = 1'b1;
      tick();
      src_rdy = 1'b0;
      chk("post_rst_lane", o_lane, 0);
      chk("post_rst_addr", o_address, 10'h0a1);
      drain(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
